// File: rtl/uart_stream_tx_if.sv
// Stream handshake bundle between a word producer and uart_stream_tx.
// Ports: s_valid/s_data from the producer, s_ready back from the transmitter FIFO.
// A word transfers on a rising clk edge where s_valid && s_ready.
interface uart_stream_tx_if #(
  parameter int W = 8
);
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/uart_stream_tx.sv
// Buffered UART transmitter: stream words into a FIFO, serialise them back-to-back (start, LSB-first data, parity, stop).
// Latency: push at N into empty idle FIFO -> pop at N+1 -> start bit on uart_tx from N+2; tx_done the cycle after the last stop cycle.
// Backpressure: s_ready = !full from the registered count (no pop bypass); tx_en low holds new frames, current frame always completes.
// Ports: clk/rst (sync, active-high); s (stream slave); tx_en; uart_tx (registered, idle high); tx_done (1-cycle pulse);
//        busy (FSM active or FIFO non-empty); fifo_level (words held).
module uart_stream_tx #(
  parameter int    CLK_FREQUENCE = 50_000_000,
  parameter int    BAUD_RATE     = 9600,
  parameter int    FRAME_WD      = 8,
  parameter string PARITY        = "NONE",
  parameter int    STOP_BITS     = 1,
  parameter int    FIFO_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  uart_stream_tx_if.slave               s,
  input  logic                          tx_en,
  output logic                          uart_tx,
  output logic                          tx_done,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int BAUD_DIV = CLK_FREQUENCE / BAUD_RATE;
  localparam int CW       = $clog2(BAUD_DIV);
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam bit PAR_EN   = (PARITY != "NONE");
  localparam bit PAR_ODD  = (PARITY == "ODD");

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic [FRAME_WD-1:0]  shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic [AW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]          cnt_q, cnt_d;
  logic [FRAME_WD-1:0]  mem_q [FIFO_DEPTH];

  logic push, pop, empty, full, bit_end;

  assign full      = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign empty     = (cnt_q == '0);
  assign s.s_ready = !full && !rst;
  assign push      = s.s_valid && s.s_ready;
  assign bit_end   = (baud_q == CW'(BAUD_DIV - 1));

  always_comb begin
    state_d = state_q;
    baud_d  = bit_end ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    pop     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        pop    = !empty && tx_en;
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_q == 4'(FRAME_WD - 1)) begin
            bit_d = '0;
            if (PAR_EN) begin
              state_d = ST_PAR;
              tx_d    = par_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            // Next bit is presented one position up before the shift lands.
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      ST_PAR: begin
        if (bit_end) begin
          state_d = ST_STOP;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (bit_q == 4'(STOP_BITS - 1)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
            pop     = !empty && tx_en;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A pop (from IDLE or end of STOP) starts a frame and realigns the bit grid.
    if (pop) begin
      state_d = ST_START;
      baud_d  = '0;
      tx_d    = 1'b0;
      shift_d = mem_q[rptr_q];
      par_d   = (^mem_q[rptr_q]) ^ PAR_ODD;
    end

    wptr_d = wptr_q + AW'(push);
    rptr_d = rptr_q + AW'(pop);
    cnt_d  = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= s.s_data;
  end

  assign uart_tx    = tx_q;
  assign tx_done    = done_q;
  assign busy       = !rst && ((state_q != ST_IDLE) || !empty);
  assign fifo_level = rst ? '0 : cnt_q;
endmodule

// File: tb/tb_uart_stream_tx.sv
// Bench for uart_stream_tx: five instances with different frame formats, each checked every cycle
// against a frame-timing model, plus a table of hand-computed expectations at fixed cycles.
module tb_uart_stream_tx;
  localparam int NI    = 5;
  localparam int BD    = 10;
  localparam int DEPTH = 4;
  localparam int TX = 0, DN = 1, BZ = 2, RD = 3, LV = 4;

  // Instance formats: 0 8N1, 1 8E1, 2 8O1, 3 8N2, 4 9N1
  function automatic int cfg_w(int i); return (i == 4) ? 9 : 8; endfunction
  function automatic int cfg_p(int i); return (i == 1) ? 1 : (i == 2) ? 2 : 0; endfunction
  function automatic int cfg_s(int i); return (i == 3) ? 2 : 1; endfunction
  function automatic int flen(int i);
    return (1 + cfg_w(i) + ((cfg_p(i) != 0) ? 1 : 0) + cfg_s(i)) * BD;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a [NI];
  logic       en_a  [NI];
  logic       vld_a [NI];
  logic [8:0] dat_a [NI];
  logic       tx_a  [NI];
  logic       done_a[NI];
  logic       busy_a[NI];
  logic       rdy_a [NI];
  logic [2:0] lvl_a [NI];

  for (genvar i = 0; i < NI; i++) begin : g
    localparam int    W   = cfg_w(i);
    localparam int    SB  = cfg_s(i);
    localparam string PAR = (i == 1) ? string'("EVEN") : (i == 2) ? string'("ODD") : string'("NONE");
    uart_stream_tx_if #(.W(W)) sif ();
    assign sif.s_valid = vld_a[i];
    assign sif.s_data  = dat_a[i][W-1:0];
    assign rdy_a[i]    = sif.s_ready;
    uart_stream_tx #(
      .CLK_FREQUENCE(1_000_000), .BAUD_RATE(100_000), .FRAME_WD(W),
      .PARITY(PAR), .STOP_BITS(SB), .FIFO_DEPTH(DEPTH)
    ) dut (
      .clk(clk), .rst(rst_a[i]), .s(sif), .tx_en(en_a[i]),
      .uart_tx(tx_a[i]), .tx_done(done_a[i]), .busy(busy_a[i]), .fifo_level(lvl_a[i])
    );
  end

  // ---------------- model: queue of words + start cycle of the frame on the wire
  int         cyc = 0;
  logic [8:0] mq    [NI][$];
  logic       m_act [NI];
  int         m_t0  [NI];
  logic [8:0] m_word[NI];
  logic       m_done[NI];
  bit         m_last, m_free, m_push;

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst_a[i]) begin
        mq[i].delete();
        m_act[i]  = 1'b0;
        m_done[i] = 1'b0;
      end else begin
        m_last = m_act[i] && (cyc == m_t0[i] + flen(i) - 1);
        m_free = !m_act[i] || m_last;
        m_push = vld_a[i] && (mq[i].size() < DEPTH);
        m_done[i] = m_last;
        if (m_last) m_act[i] = 1'b0;
        if (m_free && en_a[i] && mq[i].size() > 0) begin
          m_word[i] = mq[i].pop_front();
          m_t0[i]   = cyc + 1;
          m_act[i]  = 1'b1;
        end
        if (m_push) mq[i].push_back(dat_a[i] & ((cfg_w(i) == 9) ? 9'h1FF : 9'h0FF));
      end
    end
    cyc = cyc + 1;
  end

  function automatic logic exp_line(int i);
    int   k;
    logic par;
    if (!m_act[i]) return 1'b1;
    k = (cyc - m_t0[i]) / BD;
    if (k == 0) return 1'b0;
    if (k <= cfg_w(i)) return m_word[i][k-1];
    if (cfg_p(i) != 0 && k == cfg_w(i) + 1) begin
      par = ^m_word[i];
      return (cfg_p(i) == 2) ? ~par : par;
    end
    return 1'b1;
  endfunction

  function automatic logic [3:0] exp_sig(int i, int s);
    case (s)
      TX:      return {3'b0, exp_line(i)};
      DN:      return {3'b0, m_done[i]};
      BZ:      return rst_a[i] ? 4'd0 : {3'b0, (m_act[i] || mq[i].size() > 0)};
      RD:      return rst_a[i] ? 4'd0 : {3'b0, (mq[i].size() < DEPTH)};
      default: return rst_a[i] ? 4'd0 : 4'(mq[i].size());
    endcase
  endfunction

  function automatic logic [3:0] dut_sig(int i, int s);
    case (s)
      TX:      return {3'b0, tx_a[i]};
      DN:      return {3'b0, done_a[i]};
      BZ:      return {3'b0, busy_a[i]};
      RD:      return {3'b0, rdy_a[i]};
      default: return {1'b0, lvl_a[i]};
    endcase
  endfunction

  function automatic string sig_name(int s);
    case (s)
      TX: return "uart_tx";
      DN: return "tx_done";
      BZ: return "busy";
      RD: return "s_ready";
      default: return "fifo_level";
    endcase
  endfunction

  // ---------------- hand-computed expectations (absolute cycle, instance, signal, value)
  typedef struct { int c; int inst; int sig; int val; } pin_t;
  pin_t pins[$];
  task automatic add_pin(int c, int i, int s, int v);
    pin_t p;
    p.c = c; p.inst = i; p.sig = s; p.val = v;
    pins.push_back(p);
  endtask

  // ---------------- single compare process
  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic cmp(input string nm, input int i, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s inst%0d cycle %0d: got %0h, required %0h", nm, i, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < NI; i++)
        for (int s = 0; s < 5; s++)
          cmp(sig_name(s), i, dut_sig(i, s), exp_sig(i, s));
      foreach (pins[j]) begin
        if (pins[j].c == cyc) begin
          cmp({"pin_", sig_name(pins[j].sig)}, pins[j].inst, dut_sig(pins[j].inst, pins[j].sig), 4'(pins[j].val));
          cmp({"model_", sig_name(pins[j].sig)}, pins[j].inst, exp_sig(pins[j].inst, pins[j].sig), 4'(pins[j].val));
        end
      end
    end
  end

  task automatic wait_cyc(int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- stimulus
  initial begin
    for (int i = 0; i < NI; i++) begin
      rst_a[i] = 1'b1; en_a[i] = 1'b1; vld_a[i] = 1'b0; dat_a[i] = '0;
    end

    // reset state
    add_pin(2, 0, TX, 1); add_pin(2, 0, DN, 0); add_pin(2, 0, BZ, 0);
    add_pin(2, 0, RD, 0); add_pin(2, 0, LV, 0);
    // single word 0xA5 on 8N1, pushed at 10
    add_pin(11, 0, LV, 1);  add_pin(12, 0, LV, 0);  add_pin(12, 0, TX, 0);
    add_pin(21, 0, TX, 0);  add_pin(22, 0, TX, 1);  add_pin(32, 0, TX, 0);
    add_pin(102, 0, TX, 1); add_pin(111, 0, BZ, 1); add_pin(111, 0, DN, 0);
    add_pin(112, 0, DN, 1); add_pin(112, 0, BZ, 0); add_pin(112, 0, TX, 1);
    // parity of 0x07: EVEN -> 1, ODD -> 0
    add_pin(22, 1, TX, 1);  add_pin(22, 2, TX, 1);
    add_pin(102, 1, TX, 1); add_pin(102, 2, TX, 0); add_pin(112, 1, TX, 1);
    add_pin(112, 1, DN, 0); add_pin(122, 1, DN, 1); add_pin(122, 2, DN, 1);
    // two stop bits, tx_en low at 60, high again at 210
    add_pin(12, 3, LV, 1);  add_pin(112, 3, TX, 1); add_pin(112, 3, DN, 0);
    add_pin(122, 3, DN, 1); add_pin(160, 3, LV, 1); add_pin(160, 3, TX, 1);
    add_pin(160, 3, BZ, 1); add_pin(210, 3, TX, 1); add_pin(211, 3, TX, 0);
    add_pin(211, 3, LV, 0);
    // 9-bit word 0x1AA
    add_pin(22, 4, TX, 0);  add_pin(32, 4, TX, 1);  add_pin(82, 4, TX, 0);
    add_pin(102, 4, TX, 1); add_pin(112, 4, TX, 1); add_pin(121, 4, DN, 0);
    add_pin(122, 4, DN, 1);
    // back-to-back 0x01..0x06 from 200
    add_pin(204, 0, RD, 1); add_pin(205, 0, RD, 0); add_pin(205, 0, LV, 4);
    add_pin(212, 0, TX, 1); add_pin(301, 0, RD, 0); add_pin(302, 0, RD, 1);
    add_pin(302, 0, LV, 3); add_pin(303, 0, LV, 4); add_pin(302, 0, DN, 1);
    add_pin(302, 0, TX, 0); add_pin(312, 0, TX, 0); add_pin(322, 0, TX, 1);
    add_pin(402, 0, DN, 1); add_pin(802, 0, DN, 1); add_pin(802, 0, BZ, 0);
    // reset at 940 during a frame with two words queued, fresh push at 960
    add_pin(939, 0, LV, 2); add_pin(940, 0, TX, 0); add_pin(940, 0, LV, 0);
    add_pin(940, 0, BZ, 0); add_pin(940, 0, RD, 0); add_pin(941, 0, TX, 1);
    add_pin(941, 0, LV, 0); add_pin(941, 0, BZ, 0); add_pin(941, 0, RD, 1);
    add_pin(962, 0, TX, 0); add_pin(1062, 0, DN, 1); add_pin(1062, 0, BZ, 0);

    @(posedge clk); #1;
    chk_on = 1'b1;
    wait_cyc(3);
    for (int i = 0; i < NI; i++) rst_a[i] = 1'b0;

    wait_cyc(10);
    vld_a[0] = 1'b1; dat_a[0] = 9'h0A5;
    vld_a[1] = 1'b1; dat_a[1] = 9'h007;
    vld_a[2] = 1'b1; dat_a[2] = 9'h007;
    vld_a[3] = 1'b1; dat_a[3] = 9'h0FF;
    vld_a[4] = 1'b1; dat_a[4] = 9'h1AA;
    wait_cyc(11);
    vld_a[0] = 1'b0; vld_a[1] = 1'b0; vld_a[2] = 1'b0; vld_a[4] = 1'b0;
    dat_a[3] = 9'h000;
    wait_cyc(12);
    vld_a[3] = 1'b0;
    wait_cyc(60);
    en_a[3] = 1'b0;

    // s_valid held; data advances on the cycles the words are expected to be taken
    for (int k = 0; k < 6; k++) begin
      wait_cyc(200 + k);
      vld_a[0] = 1'b1;
      dat_a[0] = 9'(k + 1);
    end
    wait_cyc(210);
    en_a[3] = 1'b1;
    wait_cyc(303);
    vld_a[0] = 1'b0;

    for (int k = 0; k < 3; k++) begin
      wait_cyc(900 + k);
      vld_a[0] = 1'b1;
      dat_a[0] = 9'(8'h11 * (k + 1));
    end
    wait_cyc(903);
    vld_a[0] = 1'b0;
    wait_cyc(940);
    rst_a[0] = 1'b1;
    wait_cyc(941);
    rst_a[0] = 1'b0;
    wait_cyc(960);
    vld_a[0] = 1'b1; dat_a[0] = 9'h03C;
    wait_cyc(961);
    vld_a[0] = 1'b0;

    wait_cyc(1100);
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
